video_capture_packer: RTL

- Parametrised successor to the ADV pixel input stage.
- Samples the decoder pixel bus on LLC, gates it with VS/DE framing and packs PIX_PER_WORD pixels into one output word.
- Buffers packed words in a small FIFO behind a valid/ready handshake, so downstream memory-write or streaming logic can stall.
- Keeps per-frame pixel and line statistics, a frame counter and an overflow flag.

---
 rtl/capture_pkg.sv | 19 +
 rtl/video_capture_packer_if.sv | 26 ++
 rtl/capture_fifo.sv | 58 +++++
 rtl/video_capture_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and constants for the video capture packer.
package capture_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Value written into unfilled pixel slots of a flushed partial word.
  localparam int unsigned PAD_VALUE = 0;

  // Per-word framing flags carried alongside the packed data in the FIFO.
  typedef struct packed {
    logic sof;
    logic eol;
  } word_flags_t;

endpackage

// File: rtl/video_capture_packer_if.sv
// Packed-word stream from the capture packer to downstream write/stream logic.
interface video_capture_packer_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eol;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eol,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eol,
    output out_ready
  );
endinterface

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is accepted
// when a read happens on the same edge.
module capture_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/video_capture_packer.sv
// Decoder pixel capture: VS/DE framing, pixel packing, output FIFO and frame statistics.
// Build option: define CAPTURE_TESTPAT_EN to replace pixel data with a per-frame ramp.
//
// state     | meaning
// ST_SYNC   | after reset; wait for a real VS_r low sample so no partial frame is captured
// ST_ARMED  | between frames; VS_r rising starts a new frame
// ST_ACTIVE | inside a frame; pixels with DE_r high are packed, VS_r low ends the frame
module video_capture_packer
  import capture_pkg::*;
#(
  parameter int unsigned PIX_W        = 16,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned CNT_W        = 21,
  parameter int unsigned LINE_W       = 12,
  parameter int unsigned FRM_W        = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                   LLC,
  input  logic                   rst_n,
  input  logic [PIX_W-1:0]       Pixel_Bus,
  input  logic                   HS,
  input  logic                   VS,
  input  logic                   DE,
  video_capture_packer_if.master out_if,
  output logic                   hs_sync,
  output logic [CNT_W-1:0]       pixel_count,
  output logic [LINE_W-1:0]      line_count,
  output logic [FRM_W-1:0]       frame_count,
  output logic                   overflow
);
  localparam int unsigned WORD_W = PIX_W * PIX_PER_WORD;
  localparam int unsigned IDX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_WORD - 1);
  localparam logic [WORD_W-1:0] PAD_WORD = {PIX_PER_WORD{PIX_W'(PAD_VALUE)}};

  typedef struct packed {
    word_flags_t       flags;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  state_t              state_q, state_d;
  logic                vs_r_q, vs_r_d;
  logic                de_r_q, de_r_d;
  logic                hs_r_q, hs_r_d;
  logic [PIX_W-1:0]    pix_r_q, pix_r_d;
  logic                vs_p_q, vs_p_d;
  logic                in_valid_q, in_valid_d;
  logic                line_open_q, line_open_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                full_q, full_d;
  logic                sof_pend_q, sof_pend_d;
  logic [CNT_W-1:0]    pixel_count_q, pixel_count_d;
  logic [LINE_W-1:0]   line_count_q, line_count_d;
  logic [FRM_W-1:0]    frame_count_q, frame_count_d;
  logic                overflow_q, overflow_d;

  logic                accept, line_end, enq, wr_ok;
  logic [PIX_W-1:0]    pix_sel;
  fifo_entry_t         enq_entry, rd_entry;
  logic                fifo_full, fifo_empty;

`ifdef CAPTURE_TESTPAT_EN
  assign pix_sel = PIX_W'(pixel_count_q);
`else
  assign pix_sel = pix_r_q;
`endif

  // A read on the same edge frees a slot, so a full FIFO still takes the word.
  assign wr_ok = !fifo_full || (out_if.out_ready && !fifo_empty);

  always_comb begin
    vs_r_d        = VS;
    de_r_d        = DE;
    hs_r_d        = HS;
    pix_r_d       = Pixel_Bus;
    vs_p_d        = vs_r_q;
    in_valid_d    = 1'b1;
    state_d       = state_q;
    line_open_d   = 1'b0;
    idx_d         = idx_q;
    word_d        = word_q;
    full_d        = 1'b0;
    sof_pend_d    = sof_pend_q;
    pixel_count_d = pixel_count_q;
    line_count_d  = line_count_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    enq           = 1'b0;
    enq_entry     = '0;

    accept   = (state_q == ST_ACTIVE) && vs_r_q && de_r_q;
    line_end = (state_q == ST_ACTIVE) && line_open_q && !accept;

    // Emit a completed word one edge late so its eol reflects the line ending.
    if (full_q || (line_end && (idx_q != '0))) begin
      enq                 = 1'b1;
      enq_entry.flags.sof = sof_pend_q;
      enq_entry.flags.eol = line_end;
      enq_entry.data      = word_q;
      sof_pend_d          = 1'b0;
      word_d              = PAD_WORD;
      idx_d               = '0;
    end

    if (accept) begin
      word_d[idx_q*PIX_W +: PIX_W] = pix_sel;
      line_open_d = 1'b1;
      if (idx_q == IDX_LAST) begin
        full_d = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
      if (pixel_count_q != '1) begin
        pixel_count_d = pixel_count_q + CNT_W'(1);
      end
    end

    if (line_end && (line_count_q != '1)) begin
      line_count_d = line_count_q + LINE_W'(1);
    end

    if (enq && !wr_ok) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_SYNC: begin
        if (in_valid_q && !vs_r_q) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (vs_r_q && !vs_p_q) begin
          state_d       = ST_ACTIVE;
          pixel_count_d = '0;
          line_count_d  = '0;
          overflow_d    = 1'b0;
          sof_pend_d    = 1'b1;
          idx_d         = '0;
          word_d        = PAD_WORD;
        end
      end
      ST_ACTIVE: begin
        if (!vs_r_q) begin
          state_d       = ST_ARMED;
          frame_count_d = frame_count_q + FRM_W'(1);
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge LLC or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SYNC;
      vs_r_q        <= 1'b0;
      de_r_q        <= 1'b0;
      hs_r_q        <= 1'b0;
      pix_r_q       <= '0;
      vs_p_q        <= 1'b0;
      in_valid_q    <= 1'b0;
      line_open_q   <= 1'b0;
      idx_q         <= '0;
      word_q        <= '0;
      full_q        <= 1'b0;
      sof_pend_q    <= 1'b0;
      pixel_count_q <= '0;
      line_count_q  <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_r_q        <= vs_r_d;
      de_r_q        <= de_r_d;
      hs_r_q        <= hs_r_d;
      pix_r_q       <= pix_r_d;
      vs_p_q        <= vs_p_d;
      in_valid_q    <= in_valid_d;
      line_open_q   <= line_open_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      full_q        <= full_d;
      sof_pend_q    <= sof_pend_d;
      pixel_count_q <= pixel_count_d;
      line_count_q  <= line_count_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_sys (LLC),
    .rst_n   (rst_n),
    .wr_en   (enq),
    .wr_data (enq_entry),
    .rd_en   (out_if.out_ready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = rd_entry.data;
  assign out_if.out_sof   = rd_entry.flags.sof;
  assign out_if.out_eol   = rd_entry.flags.eol;

  assign hs_sync     = hs_r_q;
  assign pixel_count = pixel_count_q;
  assign line_count  = line_count_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
endmodule
